gravador_sequencia: RTL and testbench

Sequence recorder for the memory game: captures a player-entered sequence of button presses and writes it into an internal 16x4 synchronous RAM. It is the writer counterpart to the game datapath's sequence reader, so the datapath can replay and compare a player-authored sequence instead of a fixed ROM file. Recording ends on reaching the maximum length or on an inactivity timeout.

---
 rtl/gravador_sequencia_pkg.sv | 24 ++
 rtl/sync_ram_16x4.sv | 27 ++
 rtl/gravador_sequencia.sv | 162 ++++++++++++++++
 tb/tb_gravador_sequencia.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/gravador_sequencia_pkg.sv
// Shared constants for the sequence recorder: state encoding (also shown on
// db_estado), RAM geometry and a one-hot helper.
package gravador_sequencia_pkg;

    localparam int RAM_PROF = 16;
    localparam int RAM_LARG = 4;
    localparam int RAM_END  = 4;

    typedef enum logic [3:0] {
        ST_OCIOSO        = 4'h0,
        ST_ESPERA_JOGADA = 4'h1,
        ST_REGISTRA      = 4'h2,
        ST_GRAVA         = 4'h3,
        ST_ESPERA_SOLTA  = 4'h4,
        ST_PROXIMA       = 4'h5,
        ST_FIM           = 4'hA,
        ST_ERRO          = 4'hE
    } estado_t;

    function automatic logic eh_onehot(input logic [3:0] v);
        return (v != 4'b0000) && ((v & (v - 4'b0001)) == 4'b0000);
    endfunction

endpackage

// File: rtl/sync_ram_16x4.sv
// 16x4 RAM with one synchronous write port and one registered read port.
// Read-during-write to the same address returns the previous contents.
module sync_ram_16x4
    import gravador_sequencia_pkg::*;
(
    input  logic                clk,
    input  logic                i_we,
    input  logic [RAM_END-1:0]  i_wr_addr,
    input  logic [RAM_LARG-1:0] i_wr_data,
    input  logic [RAM_END-1:0]  i_rd_addr,
    output logic [RAM_LARG-1:0] o_rd_data
);

    logic [RAM_LARG-1:0] r_mem [RAM_PROF];
    logic [RAM_LARG-1:0] r_rd_data;

    // write port and registered read port
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
        r_rd_data <= r_mem[i_rd_addr];
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/gravador_sequencia.sv
// Memory-game sequence recorder: captures button presses into a 16x4 RAM until
// MAX_JOGADAS entries or an inactivity timeout. Optional: GRAVADOR_ONEHOT_CHECK_EN.
module gravador_sequencia
    import gravador_sequencia_pkg::*;
#(
    parameter int TIMEOUT     = 5000,
    parameter int MAX_JOGADAS = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic [3:0] botoes,
    input  logic [3:0] rd_endereco,
    output logic [3:0] rd_dado,
    output logic [4:0] tamanho,
    output logic       gravando,
    output logic       pronto,
    output logic       erro_timeout,
    output logic [3:0] leds,
    output logic [3:0] db_estado
);

    localparam int             TW        = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0]  TIMER_FIM = TW'(TIMEOUT - 1);
    localparam logic [4:0]     TAM_MAX   = 5'(MAX_JOGADAS);

    estado_t       r_estado;
    estado_t       w_prox;
    logic [TW-1:0] r_timer;
    logic [4:0]    r_tamanho;
    logic [3:0]    r_ptr;
    logic [3:0]    r_capturado;
    logic          r_descartado;
    logic          r_botao_ant;
    logic          r_gravando;
    logic          r_pronto;
    logic          r_erro;
    logic          r_leitura_ok;
    logic          w_borda;
    logic          w_inicio;
    logic          w_aceita;
    logic          w_we;
    logic [3:0]    w_ram_rd;

    assign w_borda  = (|botoes) & ~r_botao_ant;
    assign w_inicio = iniciar && ((r_estado == ST_OCIOSO) || (r_estado == ST_FIM) ||
                                  (r_estado == ST_ERRO));
    assign w_we     = (r_estado == ST_GRAVA);

`ifdef GRAVADOR_ONEHOT_CHECK_EN
    assign w_aceita = eh_onehot(botoes);
`else
    assign w_aceita = 1'b1;
`endif

    // next-state logic
    always_comb begin
        w_prox = r_estado;
        case (r_estado)
            ST_OCIOSO, ST_FIM, ST_ERRO: begin
                if (iniciar) begin
                    w_prox = ST_ESPERA_JOGADA;
                end else begin
                    w_prox = r_estado;
                end
            end
            ST_ESPERA_JOGADA: begin
                if (w_borda) begin
                    w_prox = ST_REGISTRA;
                end else if (r_timer == TIMER_FIM) begin
                    w_prox = (r_tamanho != 5'd0) ? ST_FIM : ST_ERRO;
                end else begin
                    w_prox = ST_ESPERA_JOGADA;
                end
            end
            ST_REGISTRA: begin
                if (w_aceita) begin
                    w_prox = ST_GRAVA;
                end else begin
                    w_prox = ST_ESPERA_SOLTA;
                end
            end
            ST_GRAVA: w_prox = ST_ESPERA_SOLTA;
            ST_ESPERA_SOLTA: begin
                // a discarded press skips PROXIMA so the write pointer stays put
                if (botoes == 4'b0000) begin
                    w_prox = r_descartado ? ST_ESPERA_JOGADA : ST_PROXIMA;
                end else begin
                    w_prox = ST_ESPERA_SOLTA;
                end
            end
            ST_PROXIMA: begin
                if (r_tamanho == TAM_MAX) begin
                    w_prox = ST_FIM;
                end else begin
                    w_prox = ST_ESPERA_JOGADA;
                end
            end
            default: w_prox = ST_OCIOSO;
        endcase
    end

    // state, datapath registers and registered status outputs
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_estado     <= ST_OCIOSO;
            r_timer      <= '0;
            r_tamanho    <= 5'd0;
            r_ptr        <= 4'd0;
            r_capturado  <= 4'd0;
            r_descartado <= 1'b0;
            r_botao_ant  <= 1'b0;
            r_gravando   <= 1'b0;
            r_pronto     <= 1'b0;
            r_erro       <= 1'b0;
            r_leitura_ok <= 1'b0;
        end else begin
            r_estado     <= w_prox;
            r_botao_ant  <= |botoes;
            r_leitura_ok <= 1'b1;
            r_timer      <= (r_estado == ST_ESPERA_JOGADA) ? (r_timer + TW'(1)) : '0;
            if (w_inicio) begin
                r_tamanho <= 5'd0;
            end else if (w_we) begin
                r_tamanho <= r_tamanho + 5'd1;
            end
            if (w_inicio) begin
                r_ptr <= 4'd0;
            end else if ((r_estado == ST_PROXIMA) && (w_prox == ST_ESPERA_JOGADA)) begin
                r_ptr <= r_ptr + 4'd1;
            end
            if (r_estado == ST_REGISTRA) begin
                r_descartado <= ~w_aceita;
                if (w_aceita) begin
                    r_capturado <= botoes;
                end
            end
            r_gravando <= !((w_prox == ST_OCIOSO) || (w_prox == ST_FIM) || (w_prox == ST_ERRO));
            r_pronto   <= (w_prox == ST_FIM);
            r_erro     <= (w_prox == ST_ERRO);
        end
    end

    sync_ram_16x4 u_ram (
        .clk       (clock),
        .i_we      (w_we),
        .i_wr_addr (r_ptr),
        .i_wr_data (r_capturado),
        .i_rd_addr (rd_endereco),
        .o_rd_data (w_ram_rd)
    );

    // RAM has no reset; hold the read data at zero until its register is loaded
    assign rd_dado      = r_leitura_ok ? w_ram_rd : 4'd0;
    assign tamanho      = r_tamanho;
    assign gravando     = r_gravando;
    assign pronto       = r_pronto;
    assign erro_timeout = r_erro;
    assign leds         = r_capturado;
    assign db_estado    = r_estado;

endmodule

// File: tb/tb_gravador_sequencia.sv
// Self-checking bench for gravador_sequencia with a small TIMEOUT and MAX_JOGADAS=4.
module tb_gravador_sequencia;
    import gravador_sequencia_pkg::*;

    localparam int TO   = 40;
    localparam int MAXJ = 4;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       iniciar = 1'b0;
    logic [3:0] botoes = 4'd0;
    logic [3:0] rd_endereco = 4'd0;
    logic [3:0] rd_dado;
    logic [4:0] tamanho;
    logic       gravando;
    logic       pronto;
    logic       erro_timeout;
    logic [3:0] leds;
    logic [3:0] db_estado;

    int         n_checks = 0;
    int         n_fail = 0;
    logic [3:0] mem_ref [16];
    int         tam_ref = 0;
    bit         ativo_ref = 1'b0;

    gravador_sequencia #(.TIMEOUT(TO), .MAX_JOGADAS(MAXJ)) dut (
        .clock        (clock),
        .reset        (reset),
        .iniciar      (iniciar),
        .botoes       (botoes),
        .rd_endereco  (rd_endereco),
        .rd_dado      (rd_dado),
        .tamanho      (tamanho),
        .gravando     (gravando),
        .pronto       (pronto),
        .erro_timeout (erro_timeout),
        .leds         (leds),
        .db_estado    (db_estado)
    );

    always #5 clock = ~clock;

    task automatic ciclos(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic comecar();
        iniciar = 1'b1;
        @(negedge clock);
        iniciar = 1'b0;
        tam_ref = 0;
        ativo_ref = 1'b1;
    endtask

    // press/release and update the reference: accepted while recording and below the limit
    task automatic apertar(input logic [3:0] v, input int seg, input int solta);
        bit aceito;
        botoes = v;
        ciclos(seg);
        botoes = 4'd0;
        ciclos(solta);
        aceito = 1'b1;
`ifdef GRAVADOR_ONEHOT_CHECK_EN
        aceito = ($countones(v) == 1);
`endif
        if (ativo_ref && aceito && tam_ref < MAXJ) begin
            mem_ref[tam_ref] = v;
            tam_ref++;
            if (tam_ref == MAXJ) ativo_ref = 1'b0;
        end
    endtask

    task automatic ler(input logic [3:0] a, output logic [3:0] d);
        rd_endereco = a;
        @(negedge clock);
        d = rd_dado;
    endtask

    task automatic esperar_fim(output int n);
        n = 0;
        while (!(pronto || erro_timeout) && n < TO + 50) begin
            @(negedge clock);
            n++;
        end
        ativo_ref = 1'b0;
    endtask

    task automatic test_reset();
        ciclos(3);
        n_checks++; if (tamanho !== 5'd0) begin n_fail++; $display("FAIL reset_tamanho: got %0d expected 0", tamanho); end
        n_checks++; if ({gravando, pronto, erro_timeout} !== 3'b000) begin n_fail++; $display("FAIL reset_flags: got %b expected 000", {gravando, pronto, erro_timeout}); end
        n_checks++; if ({leds, rd_dado} !== 8'h00) begin n_fail++; $display("FAIL reset_leds_rd: got %h expected 00", {leds, rd_dado}); end
        n_checks++; if (db_estado !== ST_OCIOSO) begin n_fail++; $display("FAIL reset_estado: got %h expected %h", db_estado, ST_OCIOSO); end
        reset = 1'b1;
        ciclos(2);
    endtask

    task automatic test_basico();
        int n;
        logic [3:0] d;
        comecar();
        n_checks++; if (gravando !== 1'b1) begin n_fail++; $display("FAIL basic_gravando: got %b expected 1", gravando); end
        botoes = 4'b0001;
        ciclos(1);
        n_checks++; if ({tamanho, leds} !== 9'd0) begin n_fail++; $display("FAIL lat_n1: got tam=%0d leds=%b expected 0/0000", tamanho, leds); end
        ciclos(1);
        n_checks++; if (leds !== 4'b0001 || tamanho !== 5'd0) begin n_fail++; $display("FAIL lat_n2: got tam=%0d leds=%b expected 0/0001", tamanho, leds); end
        ciclos(1);
        n_checks++; if (tamanho !== 5'd1) begin n_fail++; $display("FAIL lat_n3: got %0d expected 1", tamanho); end
        botoes = 4'd0;
        ciclos(3);
        mem_ref[0] = 4'b0001;
        tam_ref = 1;
        apertar(4'b0100, 3, 3);
        apertar(4'b1000, 3, 3);
        esperar_fim(n);
        n_checks++; if (pronto !== 1'b1 || erro_timeout !== 1'b0) begin n_fail++; $display("FAIL basic_pronto: got p=%b e=%b after %0d cycles expected 1/0", pronto, erro_timeout, n); end
        n_checks++; if (tamanho !== 5'(tam_ref)) begin n_fail++; $display("FAIL basic_tamanho: got %0d expected %0d", tamanho, tam_ref); end
        for (int i = 0; i < 3; i++) begin
            ler(i[3:0], d);
            n_checks++; if (d !== mem_ref[i]) begin n_fail++; $display("FAIL basic_ram[%0d]: got %b expected %b", i, d, mem_ref[i]); end
        end
    endtask

    task automatic test_timeout();
        comecar();
        ciclos(TO - 1);
        n_checks++; if (erro_timeout !== 1'b0 || gravando !== 1'b1) begin n_fail++; $display("FAIL to_early: got e=%b g=%b expected 0/1", erro_timeout, gravando); end
        ciclos(1);
        n_checks++; if (erro_timeout !== 1'b1 || gravando !== 1'b0 || pronto !== 1'b0) begin n_fail++; $display("FAIL to_erro: got e=%b g=%b p=%b expected 1/0/0", erro_timeout, gravando, pronto); end
        n_checks++; if (tamanho !== 5'd0) begin n_fail++; $display("FAIL to_tamanho: got %0d expected 0", tamanho); end
        ativo_ref = 1'b0;
    endtask

    task automatic test_max();
        logic [3:0] d;
        comecar();
        apertar(4'b0010, 3, 3);
        apertar(4'b1000, 3, 3);
        apertar(4'b0001, 3, 3);
        apertar(4'b0100, 3, 3);
        n_checks++; if (pronto !== 1'b1) begin n_fail++; $display("FAIL max_pronto: got %b expected 1", pronto); end
        apertar(4'b1000, 3, 3);
        n_checks++; if (tamanho !== 5'd4 || gravando !== 1'b0) begin n_fail++; $display("FAIL max_tamanho: got %0d g=%b expected 4/0", tamanho, gravando); end
        for (int i = 0; i < MAXJ; i++) begin
            ler(i[3:0], d);
            n_checks++; if (d !== mem_ref[i]) begin n_fail++; $display("FAIL max_ram[%0d]: got %b expected %b", i, d, mem_ref[i]); end
        end
    endtask

    task automatic test_onehot();
        int n;
        logic [3:0] d;
        comecar();
        apertar(4'b0011, 3, 3);
        n_checks++; if (tamanho !== 5'(tam_ref)) begin n_fail++; $display("FAIL onehot_tamanho: got %0d expected %0d", tamanho, tam_ref); end
        apertar(4'b0100, 3, 3);
        esperar_fim(n);
        n_checks++; if (tamanho !== 5'(tam_ref) || pronto !== 1'b1) begin n_fail++; $display("FAIL onehot_fim: got %0d p=%b expected %0d/1", tamanho, pronto, tam_ref); end
        ler(4'd0, d);
        n_checks++; if (d !== mem_ref[0]) begin n_fail++; $display("FAIL onehot_ram0: got %b expected %b", d, mem_ref[0]); end
    endtask

    task automatic test_segura_longo();
        int n;
        logic [3:0] d;
        comecar();
        botoes = 4'b0010;
        ciclos(10);
        iniciar = 1'b1;
        ciclos(1);
        iniciar = 1'b0;
        ciclos(39);
        botoes = 4'd0;
        ciclos(3);
        mem_ref[0] = 4'b0010;
        tam_ref = 1;
        n_checks++; if (tamanho !== 5'd1 || gravando !== 1'b1) begin n_fail++; $display("FAIL hold_tamanho: got %0d g=%b expected 1/1", tamanho, gravando); end
        esperar_fim(n);
        n_checks++; if (pronto !== 1'b1 || tamanho !== 5'd1) begin n_fail++; $display("FAIL hold_fim: got p=%b tam=%0d expected 1/1", pronto, tamanho); end
        ler(4'd0, d);
        n_checks++; if (d !== 4'b0010) begin n_fail++; $display("FAIL hold_ram0: got %b expected 0010", d); end
    endtask

    task automatic test_aleatorio();
        int n, k;
        logic [3:0] v, um, d;
        um = 4'b0001;
        for (int it = 0; it < 3; it++) begin
            comecar();
            k = $urandom_range(1, MAXJ);
            for (int j = 0; j < k; j++) begin
                v = um << $urandom_range(0, 3);
                apertar(v, $urandom_range(2, 6), $urandom_range(2, 5));
            end
            esperar_fim(n);
            n_checks++; if (pronto !== 1'b1 || tamanho !== 5'(tam_ref)) begin n_fail++; $display("FAIL rnd_fim[%0d]: got p=%b tam=%0d expected 1/%0d", it, pronto, tamanho, tam_ref); end
            for (int i = 0; i < tam_ref; i++) begin
                ler(i[3:0], d);
                n_checks++; if (d !== mem_ref[i]) begin n_fail++; $display("FAIL rnd_ram[%0d][%0d]: got %b expected %b", it, i, d, mem_ref[i]); end
            end
        end
    endtask

    task automatic test_reset_meio();
        logic [3:0] d;
        comecar();
        apertar(4'b1000, 3, 3);
        botoes = 4'b0001;
        ciclos(6);
        mem_ref[1] = 4'b0001;
        n_checks++; if (tamanho !== 5'd2 || db_estado !== ST_ESPERA_SOLTA) begin n_fail++; $display("FAIL rm_pre: got tam=%0d st=%h expected 2/%h", tamanho, db_estado, ST_ESPERA_SOLTA); end
        reset = 1'b0;
        #1;
        n_checks++; if ({gravando, pronto, erro_timeout} !== 3'b000 || tamanho !== 5'd0) begin n_fail++; $display("FAIL rm_abort: got flags=%b tam=%0d expected 000/0", {gravando, pronto, erro_timeout}, tamanho); end
        ciclos(2);
        botoes = 4'd0;
        reset = 1'b1;
        ciclos(2);
        n_checks++; if (db_estado !== ST_OCIOSO || tamanho !== 5'd0) begin n_fail++; $display("FAIL rm_ocioso: got st=%h tam=%0d expected %h/0", db_estado, tamanho, ST_OCIOSO); end
        ler(4'd0, d);
        n_checks++; if (d !== 4'b1000) begin n_fail++; $display("FAIL rm_ram0: got %b expected 1000", d); end
    endtask

    initial begin
        test_reset();
        test_basico();
        test_timeout();
        test_max();
        test_onehot();
        test_segura_longo();
        test_aleatorio();
        test_reset_meio();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
